stream_cipher_arb: RTL and testbench
====================================

# stream_cipher_arb

Round-robin controller that shares one `stream_cipher` instance between `N_CH` independent byte-stream channels. Each channel keeps its own 8-bit counter context. On every channel switch the controller reloads the cipher through its key port, so each channel sees an uninterrupted keystream. The block sits between the channel requesters and the cipher's `key`/`key_in`/`din`/`din_valid`/`dout`/`dout_valid` ports, and tags each ciphertext byte with its channel.

## Interface
- `N_CH`, 2: number of channels (2..8).
- `MAX_BURST`, 16: maximum beats per grant while another channel is pending (1..255).
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous, active-low. The cipher shares this net.
- `ch_key_set` in N_CH: per-channel one-cycle pulse that loads `ch_key` into that channel's context.
- `ch_key` in 8*N_CH: per-channel key; slice i is `[8i+7:8i]`.
- `ch_valid` in N_CH: per-channel plaintext byte available.
- `ch_data` in 8*N_CH: per-channel plaintext byte.
- `ch_ready` out N_CH: byte accepted when `ch_valid[i] & ch_ready[i]` (a beat).
- `cs_key` out 8: to cipher `key`.
- `cs_key_in` out 1: to cipher `key_in`.
- `cs_din` out 8: to cipher `din`.
- `cs_din_valid` out 1: to cipher `din_valid`.
- `cs_dout` in 8: from cipher `dout`.
- `cs_dout_valid` in 1: from cipher `dout_valid`.
- `out_data` out 8: ciphertext byte, equal to `cs_dout`.
- `out_valid` out 1: equal to `cs_dout_valid`. There is no backpressure.
- `out_ch` out clog2(N_CH): channel tag of `out_data`.
- `beat_cnt` out 16*N_CH: per-channel statistics (see Configuration).

## Operation
- State held: FSM {IDLE, LOAD, STREAM}, owner `own`, flag `sync` (cipher counter equals `ctx[own]`), `ctx[N_CH]` 8-bit, rr pointer, 8-bit burst counter, and registered tag `tag_q`.
- **Key set.** `ch_key_set[i]` writes `ctx[i] <= ch_key[i]` in any state. It overrides a same-cycle increment, forces `ch_ready[i]=0` that cycle, and clears `sync` if `i == own`.
- **IDLE.** Pick the round-robin winner among `ch_valid` bits, starting at pointer+1 modulo N_CH.
  - No winner: stay in IDLE.
  - Winner equals `own` and `sync=1`: go to STREAM.
  - Otherwise: go to LOAD with `own <= winner`.
  - Always clear the burst counter.
- **LOAD.** Drive `cs_key_in=1` and `cs_key=ctx[own]` for exactly one cycle, set `sync<=1`, then go to STREAM. `ch_ready` is all 0.
- **STREAM.**
  - `ch_ready[own] = ~ch_key_set[own]`; all other ready bits are 0.
  - `cs_din = ch_data[own]` and `cs_din_valid` = beat.
  - On a beat: `ctx[own] <= ctx[own]+1`, wrapping 0xFF to 0x00; `tag_q <= own`; burst counter +1.
  - Exit to IDLE when any of these holds: `ch_valid[own]=0`; `ch_key_set[own]=1`; or the burst counter reaches `MAX_BURST` after this beat while another `ch_valid` bit is set. The rr pointer is set to `own` on exit.
  - With no other requester, the burst counter saturates and the grant continues.
- **Output.** `out_data=cs_dout`, `out_valid=cs_dout_valid`, `out_ch=tag_q`.

## Timing
- A beat on cycle T produces `out_valid=1` on cycle T+1, carrying `out_ch` of the T channel.
- Sustained throughput within a grant is 1 byte/cycle.
- A switch to a different channel costs 1 LOAD cycle plus the IDLE arbitration cycle.
- Resuming the same synced channel costs 1 IDLE cycle only; there is no LOAD.
- `cs_key_in` and `cs_din_valid` are never high in the same cycle.
- Reset values, on the edge where `rst_n=0`:
  - FSM=IDLE, `sync=0`, `own=0`, pointer=N_CH-1, all `ctx=0`, `tag_q=0`, burst counter 0, `beat_cnt=0`.
  - Consequently `ch_ready`, `cs_key_in` and `cs_din_valid` are 0, and `out_valid` is 0 (the cipher is also reset).
- Reset mid-burst drops the burst; in-flight bytes are not produced.

## Configuration
- `STREAM_ARB_STATS_EN` defined:
  - `beat_cnt[i]` is a 16-bit counter that increments on each channel-i beat and saturates at 0xFFFF.
  - It is cleared on reset only.
- Undefined: `beat_cnt` is tied to 0 and no counter logic is generated.

## Structure
- Package `stream_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, LOAD, STREAM);
  - `DATA_W=8`, `CTX_W=8`, `STAT_W=16`.
- Sub-module `rr_arbiter`: combinational N-bit round-robin priority pick, with inputs `req` and `ptr` and outputs `gnt_idx` and `gnt_any`.

## Test plan
- **Single channel.** Channel 0: `ch_key_set` with key 0x10, then 3 beats of 0x00.
  - LOAD cycle shows `cs_key=0x10` with `cs_key_in=1`.
  - `out_data` = `sbox(0x10)`, `sbox(0x11)`, `sbox(0x12)`, all with `out_ch=0`.
  - `ctx[0]` ends at 0x13.
- **Two-channel round-robin.** `MAX_BURST=4`; ch0 key 0x20 and ch1 key 0x80, both continuously valid.
  - Expected sequence: ch0 4 beats; LOAD 0x80; ch1 4 beats; LOAD 0x24; ch0 resumes.
- **Counter wrap.** ch0 key 0xFE, 3 beats, then a switch to ch1 and back.
  - On return, LOAD shows `cs_key=0x01`.
- **Key set mid-burst.** `ch_key_set[own]` with 0x55 during STREAM.
  - `ch_ready` is 0 that cycle and no increment occurs.
  - Then IDLE, then LOAD with `cs_key=0x55`, then beats resume.
- **Reset mid-operation.** `rst_n=0` for 1 cycle during a burst.
  - Next cycle: `ch_ready=0`, `out_valid=0`, `ctx=0`.
  - The next grant issues LOAD with `cs_key=0x00`.
- **Statistics.** With `STREAM_ARB_STATS_EN`, 70000 beats on ch1 give `beat_cnt[1]=0xFFFF` and `beat_cnt[0]=0`. Without the macro, all counters read 0.

Source files
------------

// File: rtl/stream_cipher_arb_pkg.sv
// stream_arb_pkg
// Shared types and widths for the stream cipher arbiter slice.
//   arb_state_t : controller FSM states (IDLE, LOAD, STREAM)
//   DATA_W      : width of plaintext/ciphertext bytes
//   CTX_W       : width of a channel's cipher counter context
//   STAT_W      : width of a per-channel beat statistic counter
package stream_arb_pkg;

  localparam int DATA_W = 8;
  localparam int CTX_W  = 8;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } arb_state_t;

endpackage

// File: rtl/stream_cipher_arb_if.sv
// stream_cipher_arb_if
// Bus between the arbiter and the shared stream_cipher instance.
//   cs_key        : key/counter value to load into the cipher
//   cs_key_in     : one-cycle load strobe for cs_key
//   cs_din        : plaintext byte to the cipher
//   cs_din_valid  : plaintext byte valid (one cipher step)
//   cs_dout       : ciphertext byte from the cipher
//   cs_dout_valid : ciphertext byte valid
// Modports: master = arbiter side, slave = cipher side.
interface stream_cipher_arb_if;
  import stream_arb_pkg::*;

  logic [DATA_W-1:0] cs_key;
  logic              cs_key_in;
  logic [DATA_W-1:0] cs_din;
  logic              cs_din_valid;
  logic [DATA_W-1:0] cs_dout;
  logic              cs_dout_valid;

  modport master (
    output cs_key, cs_key_in, cs_din, cs_din_valid,
    input  cs_dout, cs_dout_valid
  );

  modport slave (
    input  cs_key, cs_key_in, cs_din, cs_din_valid,
    output cs_dout, cs_dout_valid
  );

endinterface

// File: rtl/stream_cipher_arb_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin pick over N request lines.
//   req     : request bits
//   ptr     : last winner; search starts at ptr+1 and wraps
//   gnt_idx : index of the winning request (0 when none)
//   gnt_any : at least one request is set
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_any
);

  localparam int IW = $clog2(N);

  int idx;

  // Walk offsets from farthest (ptr itself) to nearest (ptr+1) so the
  // last matching write is the highest-priority requester.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_idx = IW'(idx);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_cipher_arb.sv
// stream_cipher_arb
// Shares one stream_cipher between N_CH byte-stream channels. Each channel
// owns an 8-bit counter context; switching channels reloads the cipher via
// its key port so every channel sees a continuous keystream.
//   clk, rst_n    : clock, synchronous active-low reset (shared with cipher)
//   ch_key_set    : per-channel pulse loading ch_key slice into its context
//   ch_key        : per-channel key, slice i = [8i+7:8i]
//   ch_valid      : per-channel plaintext available
//   ch_data       : per-channel plaintext byte
//   ch_ready      : per-channel accept (beat = valid & ready)
//   cs            : cipher bus (master modport)
//   out_data      : ciphertext byte (cipher dout)
//   out_valid     : ciphertext valid (cipher dout_valid)
//   out_ch        : channel tag of out_data
//   beat_cnt      : per-channel 16-bit beat statistics
// Optional feature: define STREAM_ARB_STATS_EN to build saturating beat
// counters; otherwise beat_cnt reads 0.
module stream_cipher_arb
  import stream_arb_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           ch_key_set,
  input  logic [CTX_W*N_CH-1:0]     ch_key,
  input  logic [N_CH-1:0]           ch_valid,
  input  logic [DATA_W*N_CH-1:0]    ch_data,
  output logic [N_CH-1:0]           ch_ready,
  stream_cipher_arb_if.master       cs,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic [$clog2(N_CH)-1:0]   out_ch,
  output logic [STAT_W*N_CH-1:0]    beat_cnt
);

  localparam int IDX_W = $clog2(N_CH);

  arb_state_t       state;
  logic [IDX_W-1:0] own;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] tag_q;
  logic             sync;
  logic [CTX_W-1:0] ctx [N_CH];
  logic [7:0]       burst;

  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic [N_CH-1:0]  own_onehot;
  logic             own_valid;
  logic             own_key_set;
  logic             beat;
  logic             others_pending;
  logic             burst_hit;
  logic             sync_eff;

  rr_arbiter #(.N(N_CH)) u_rr (
    .req     (ch_valid),
    .ptr     (rr_ptr),
    .gnt_idx (win_idx),
    .gnt_any (win_any)
  );

  // Decode the current owner's view of the inputs. A key set on the owner
  // blocks its beat and invalidates the cipher's counter copy immediately,
  // so a same-cycle resume from IDLE must not skip the reload.
  always_comb begin
    own_onehot      = '0;
    own_onehot[own] = 1'b1;
    own_valid       = ch_valid[own];
    own_key_set     = ch_key_set[own];
    beat            = (state == STREAM) && own_valid && !own_key_set;
    others_pending  = |(ch_valid & ~own_onehot);
    burst_hit       = ({1'b0, burst} + 9'd1) >= 9'(MAX_BURST);
    sync_eff        = sync && !own_key_set;
  end

  // Cipher-facing and requester-facing outputs follow the FSM state.
  always_comb begin
    ch_ready        = (state == STREAM && !own_key_set) ? own_onehot : '0;
    cs.cs_key       = ctx[own];
    cs.cs_key_in    = (state == LOAD);
    cs.cs_din       = ch_data[DATA_W*own +: DATA_W];
    cs.cs_din_valid = beat;
    out_data        = cs.cs_dout;
    out_valid       = cs.cs_dout_valid;
    out_ch          = tag_q;
  end

  // Controller FSM: arbitrate in IDLE, reload the cipher in LOAD (skipped
  // when the same owner resumes while still in sync), then stream beats
  // until the owner stops, rekeys, or uses up its burst while others wait.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      own    <= '0;
      sync   <= 1'b0;
      rr_ptr <= IDX_W'(N_CH - 1);
      burst  <= '0;
      tag_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          burst <= '0;
          if (win_any) begin
            if (win_idx == own && sync_eff) begin
              state <= STREAM;
            end else begin
              state <= LOAD;
              own   <= win_idx;
            end
          end
        end
        LOAD: begin
          sync  <= 1'b1;
          state <= STREAM;
        end
        STREAM: begin
          if (beat) begin
            tag_q <= own;
            burst <= burst_hit ? 8'(MAX_BURST) : burst + 8'd1;
          end
          if (!own_valid || own_key_set || (beat && burst_hit && others_pending)) begin
            state  <= IDLE;
            rr_ptr <= own;
          end
        end
        default: state <= IDLE;
      endcase
      if (own_key_set) sync <= 1'b0;
    end
  end

  // Channel counter contexts: a key load wins over the owner's increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) ctx[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_key_set[i]) begin
          ctx[i] <= ch_key[CTX_W*i +: CTX_W];
        end else if (beat && own == IDX_W'(i)) begin
          ctx[i] <= ctx[i] + 1'b1;
        end
      end
    end
  end

`ifdef STREAM_ARB_STATS_EN
  logic [STAT_W-1:0] stat [N_CH];

  // Saturating per-channel beat counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) stat[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (beat && own == IDX_W'(i) && stat[i] != '1) stat[i] <= stat[i] + 1'b1;
      end
    end
  end

  // Flatten the counters onto the statistics port.
  always_comb begin
    beat_cnt = '0;
    for (int i = 0; i < N_CH; i++) beat_cnt[STAT_W*i +: STAT_W] = stat[i];
  end
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_cipher_arb.sv
// tb_stream_cipher_arb
// Directed bench for stream_cipher_arb with N_CH=2, MAX_BURST=4 and a
// behavioural stream_cipher stub on the cipher bus: key_in loads the
// counter, each din_valid emits din ^ sbox(counter) and advances it.
module tb_stream_cipher_arb;
  import stream_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  ch_key_set;
  logic [15:0] ch_key;
  logic [1:0]  ch_valid;
  logic [15:0] ch_data;
  logic [1:0]  ch_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [0:0]  out_ch;
  logic [31:0] beat_cnt;

  int errors = 0;
  int checks = 0;

  stream_cipher_arb_if cs_if ();

  stream_cipher_arb #(.N_CH(2), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_key_set (ch_key_set),
    .ch_key     (ch_key),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .ch_ready   (ch_ready),
    .cs         (cs_if),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .beat_cnt   (beat_cnt)
  );

  // Arbitrary byte substitution standing in for the cipher's keystream.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = {x[4:0], x[7:5]} ^ {x[0], x[7:1]} ^ 8'h63;
  endfunction

  logic [7:0] cip_ctr;

  // Cipher stub: registered output, reset along with the arbiter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cip_ctr              <= 8'h00;
      cs_if.cs_dout        <= 8'h00;
      cs_if.cs_dout_valid  <= 1'b0;
    end else begin
      cs_if.cs_dout_valid <= cs_if.cs_din_valid;
      if (cs_if.cs_key_in) begin
        cip_ctr <= cs_if.cs_key;
      end else if (cs_if.cs_din_valid) begin
        cs_if.cs_dout <= cs_if.cs_din ^ sbox(cip_ctr);
        cip_ctr       <= cip_ctr + 8'h01;
      end
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Load strobe and data strobe to the cipher must never coincide.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (cs_if.cs_key_in && cs_if.cs_din_valid) begin
        errors++;
        $display("[TB] FAIL key_in_din_overlap got key_in=%b din_valid=%b exp not both 1", cs_if.cs_key_in, cs_if.cs_din_valid);
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog got timeout exp finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] ks, input logic [15:0] key,
                               input logic [1:0] v, input logic [15:0] d);
    ch_key_set = ks;
    ch_key     = key;
    ch_valid   = v;
    ch_data    = d;
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    ch_key_set = '0;
    ch_key     = '0;
    ch_valid   = '0;
    ch_data    = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (ch_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=%b", ch_ready, 2'b00); end
    checks++; if (cs_if.cs_key_in !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_in got=%b exp=0", cs_if.cs_key_in); end
    checks++; if (cs_if.cs_din_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_din_valid got=%b exp=0", cs_if.cs_din_valid); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_ch !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_ch got=%0d exp=0", out_ch); end
    checks++; if (beat_cnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_beat_cnt got=%h exp=0", beat_cnt); end
  endtask

  task automatic test_single();
    logic [7:0] c;
    do_reset();
    applyStimulus(2'b01, 16'h0010, 2'b00, 16'h0000);
    step();
    applyStimulus(2'b00, 16'h0000, 2'b01, 16'h0000);
    checks++; if (ch_ready !== 2'b00) begin errors++; $display("[TB] FAIL single_idle_ready got=%b exp=00", ch_ready); end
    step();
    checks++; if (cs_if.cs_key_in !== 1'b1) begin errors++; $display("[TB] FAIL single_load_key_in got=%b exp=1", cs_if.cs_key_in); end
    checks++; if (cs_if.cs_key !== 8'h10) begin errors++; $display("[TB] FAIL single_load_key got=%h exp=10", cs_if.cs_key); end
    checks++; if (ch_ready !== 2'b00) begin errors++; $display("[TB] FAIL single_load_ready got=%b exp=00", ch_ready); end
    step();
    for (int k = 0; k < 3; k++) begin
      checks++; if (ch_ready !== 2'b01) begin errors++; $display("[TB] FAIL single_ready[%0d] got=%b exp=01", k, ch_ready); end
      checks++; if (cs_if.cs_din_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_din_valid[%0d] got=%b exp=1", k, cs_if.cs_din_valid); end
      if (k > 0) begin
        c = 8'h10 + 8'(k - 1);
        checks++; if (out_valid !== 1'b1 || out_data !== sbox(c) || out_ch !== 1'b0) begin errors++; $display("[TB] FAIL single_out[%0d] got v=%b d=%h ch=%0d exp v=1 d=%h ch=0", k, out_valid, out_data, out_ch, sbox(c)); end
      end
      step();
    end
    applyStimulus(2'b00, 16'h0000, 2'b00, 16'h0000);
    checks++; if (out_valid !== 1'b1 || out_data !== sbox(8'h12) || out_ch !== 1'b0) begin errors++; $display("[TB] FAIL single_out[3] got v=%b d=%h ch=%0d exp v=1 d=%h ch=0", out_valid, out_data, out_ch, sbox(8'h12)); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_out_end got=%b exp=0", out_valid); end
    checks++; if (dut.ctx[0] !== 8'h13) begin errors++; $display("[TB] FAIL single_ctx0 got=%h exp=13", dut.ctx[0]); end
  endtask

  task automatic test_round_robin();
    logic [7:0] c;
    do_reset();
    applyStimulus(2'b11, 16'h8020, 2'b00, 16'h0000);
    step();
    applyStimulus(2'b00, 16'h0000, 2'b11, 16'hF00F);
    step();
    checks++; if (cs_if.cs_key_in !== 1'b1 || cs_if.cs_key !== 8'h20) begin errors++; $display("[TB] FAIL rr_load0 got key_in=%b key=%h exp key_in=1 key=20", cs_if.cs_key_in, cs_if.cs_key); end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (ch_ready !== 2'b01) begin errors++; $display("[TB] FAIL rr_ch0_ready[%0d] got=%b exp=01", k, ch_ready); end
      if (k > 0) begin
        c = 8'h20 + 8'(k - 1);
        checks++; if (out_valid !== 1'b1 || out_data !== (sbox(c) ^ 8'h0F) || out_ch !== 1'b0) begin errors++; $display("[TB] FAIL rr_ch0_out[%0d] got v=%b d=%h ch=%0d exp v=1 d=%h ch=0", k, out_valid, out_data, out_ch, sbox(c) ^ 8'h0F); end
      end
      step();
    end
    checks++; if (ch_ready !== 2'b00 || cs_if.cs_key_in !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle0 got ready=%b key_in=%b exp ready=00 key_in=0", ch_ready, cs_if.cs_key_in); end
    checks++; if (out_valid !== 1'b1 || out_data !== (sbox(8'h23) ^ 8'h0F) || out_ch !== 1'b0) begin errors++; $display("[TB] FAIL rr_ch0_last got v=%b d=%h ch=%0d exp v=1 d=%h ch=0", out_valid, out_data, out_ch, sbox(8'h23) ^ 8'h0F); end
    step();
    checks++; if (cs_if.cs_key_in !== 1'b1 || cs_if.cs_key !== 8'h80) begin errors++; $display("[TB] FAIL rr_load1 got key_in=%b key=%h exp key_in=1 key=80", cs_if.cs_key_in, cs_if.cs_key); end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++; if (ch_ready !== 2'b10) begin errors++; $display("[TB] FAIL rr_ch1_ready[%0d] got=%b exp=10", k, ch_ready); end
      if (k > 0) begin
        c = 8'h80 + 8'(k - 1);
        checks++; if (out_valid !== 1'b1 || out_data !== (sbox(c) ^ 8'hF0) || out_ch !== 1'b1) begin errors++; $display("[TB] FAIL rr_ch1_out[%0d] got v=%b d=%h ch=%0d exp v=1 d=%h ch=1", k, out_valid, out_data, out_ch, sbox(c) ^ 8'hF0); end
      end
      step();
    end
    checks++; if (ch_ready !== 2'b00) begin errors++; $display("[TB] FAIL rr_idle1 got=%b exp=00", ch_ready); end
    step();
    checks++; if (cs_if.cs_key_in !== 1'b1 || cs_if.cs_key !== 8'h24) begin errors++; $display("[TB] FAIL rr_reload0 got key_in=%b key=%h exp key_in=1 key=24", cs_if.cs_key_in, cs_if.cs_key); end
    step();
    checks++; if (ch_ready !== 2'b01) begin errors++; $display("[TB] FAIL rr_resume_ready got=%b exp=01", ch_ready); end
    step();
    applyStimulus(2'b00, 16'h0000, 2'b00, 16'h0000);
    checks++; if (out_valid !== 1'b1 || out_data !== (sbox(8'h24) ^ 8'h0F) || out_ch !== 1'b0) begin errors++; $display("[TB] FAIL rr_resume_out got v=%b d=%h ch=%0d exp v=1 d=%h ch=0", out_valid, out_data, out_ch, sbox(8'h24) ^ 8'h0F); end
    step();
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    applyStimulus(2'b11, 16'h40FE, 2'b00, 16'h0000);
    step();
    applyStimulus(2'b00, 16'h0000, 2'b01, 16'h0000);
    step();
    checks++; if (cs_if.cs_key !== 8'hFE) begin errors++; $display("[TB] FAIL wrap_load got=%h exp=FE", cs_if.cs_key); end
    step();
    step();
    step();
    checks++; if (out_valid !== 1'b1 || out_data !== sbox(8'hFF)) begin errors++; $display("[TB] FAIL wrap_out_ff got v=%b d=%h exp v=1 d=%h", out_valid, out_data, sbox(8'hFF)); end
    step();
    applyStimulus(2'b00, 16'h0000, 2'b10, 16'h0000);
    checks++; if (out_valid !== 1'b1 || out_data !== sbox(8'h00)) begin errors++; $display("[TB] FAIL wrap_out_00 got v=%b d=%h exp v=1 d=%h", out_valid, out_data, sbox(8'h00)); end
    step();
    step();
    checks++; if (cs_if.cs_key_in !== 1'b1 || cs_if.cs_key !== 8'h40) begin errors++; $display("[TB] FAIL wrap_load1 got key_in=%b key=%h exp key_in=1 key=40", cs_if.cs_key_in, cs_if.cs_key); end
    step();
    step();
    step();
    applyStimulus(2'b00, 16'h0000, 2'b01, 16'h0000);
    step();
    step();
    checks++; if (cs_if.cs_key_in !== 1'b1 || cs_if.cs_key !== 8'h01) begin errors++; $display("[TB] FAIL wrap_return_load got key_in=%b key=%h exp key_in=1 key=01", cs_if.cs_key_in, cs_if.cs_key); end
    applyStimulus(2'b00, 16'h0000, 2'b00, 16'h0000);
    step();
    step();
  endtask

  task automatic test_key_set_mid();
    do_reset();
    applyStimulus(2'b01, 16'h0030, 2'b00, 16'h0000);
    step();
    applyStimulus(2'b00, 16'h0000, 2'b01, 16'h0000);
    step();
    step();
    step();
    step();
    applyStimulus(2'b01, 16'h0055, 2'b01, 16'h0000);
    checks++; if (ch_ready !== 2'b00 || cs_if.cs_din_valid !== 1'b0) begin errors++; $display("[TB] FAIL keymid_block got ready=%b din_valid=%b exp ready=00 din_valid=0", ch_ready, cs_if.cs_din_valid); end
    step();
    applyStimulus(2'b00, 16'h0000, 2'b01, 16'h0000);
    checks++; if (dut.ctx[0] !== 8'h55) begin errors++; $display("[TB] FAIL keymid_ctx got=%h exp=55", dut.ctx[0]); end
    checks++; if (ch_ready !== 2'b00 || cs_if.cs_key_in !== 1'b0) begin errors++; $display("[TB] FAIL keymid_idle got ready=%b key_in=%b exp ready=00 key_in=0", ch_ready, cs_if.cs_key_in); end
    step();
    checks++; if (cs_if.cs_key_in !== 1'b1 || cs_if.cs_key !== 8'h55) begin errors++; $display("[TB] FAIL keymid_load got key_in=%b key=%h exp key_in=1 key=55", cs_if.cs_key_in, cs_if.cs_key); end
    step();
    checks++; if (ch_ready !== 2'b01) begin errors++; $display("[TB] FAIL keymid_resume got=%b exp=01", ch_ready); end
    step();
    applyStimulus(2'b00, 16'h0000, 2'b00, 16'h0000);
    checks++; if (out_valid !== 1'b1 || out_data !== sbox(8'h55)) begin errors++; $display("[TB] FAIL keymid_out got v=%b d=%h exp v=1 d=%h", out_valid, out_data, sbox(8'h55)); end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    applyStimulus(2'b01, 16'h0077, 2'b00, 16'h0000);
    step();
    applyStimulus(2'b00, 16'h0000, 2'b01, 16'h0000);
    step();
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (ch_ready !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_ready got=%b exp=00", ch_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (dut.ctx[0] !== 8'h00 || dut.ctx[1] !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_ctx got=%h/%h exp=00/00", dut.ctx[0], dut.ctx[1]); end
    checks++; if (beat_cnt !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_beat_cnt got=%h exp=0", beat_cnt); end
    step();
    checks++; if (cs_if.cs_key_in !== 1'b1 || cs_if.cs_key !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_load got key_in=%b key=%h exp key_in=1 key=00", cs_if.cs_key_in, cs_if.cs_key); end
    applyStimulus(2'b00, 16'h0000, 2'b00, 16'h0000);
    step();
    step();
  endtask

  task automatic test_stats();
    do_reset();
    applyStimulus(2'b10, 16'h1000, 2'b00, 16'h0000);
    step();
    applyStimulus(2'b00, 16'h0000, 2'b10, 16'h0000);
    step();
    step();
`ifdef STREAM_ARB_STATS_EN
    for (int k = 0; k < 100; k++) step();
    checks++; if (beat_cnt[31:16] !== 16'd100 || beat_cnt[15:0] !== 16'd0) begin errors++; $display("[TB] FAIL stats_100 got=%h exp=00640000", beat_cnt); end
    for (int k = 0; k < 70000; k++) step();
    checks++; if (beat_cnt[31:16] !== 16'hFFFF) begin errors++; $display("[TB] FAIL stats_sat got=%h exp=FFFF", beat_cnt[31:16]); end
    checks++; if (beat_cnt[15:0] !== 16'h0000) begin errors++; $display("[TB] FAIL stats_ch0 got=%h exp=0000", beat_cnt[15:0]); end
`else
    for (int k = 0; k < 20; k++) step();
    checks++; if (beat_cnt !== 32'h0) begin errors++; $display("[TB] FAIL stats_off got=%h exp=0", beat_cnt); end
`endif
    applyStimulus(2'b00, 16'h0000, 2'b00, 16'h0000);
    step();
    step();
  endtask

  initial begin
    rst_n      = 1'b0;
    ch_key_set = '0;
    ch_key     = '0;
    ch_valid   = '0;
    ch_data    = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_key_set_mid();
    test_reset_mid();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
